// File: rtl/h14tx_timings_detect.sv
// Sink-side video timing detector: measures hsync/vsync/de geometry, locks on stable frames, regenerates x/y.
// Optional TIMING_DET_POLARITY_EN adds automatic sync polarity detection (hsync_pol/vsync_pol outputs).
module h14tx_timings_detect #(
    parameter int BitWidth   = 12,
    parameter int BitHeight  = 12,
    parameter int LockFrames = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 de,
    output logic [BitWidth-1:0]  x,
    output logic [BitHeight-1:0] y,
    output logic                 de_o,
    output logic [BitWidth-1:0]  h_total,
    output logic [BitWidth-1:0]  h_active,
    output logic [BitHeight-1:0] v_total,
    output logic [BitHeight-1:0] v_active,
    output logic                 locked,
    output logic                 lock_lost
`ifdef TIMING_DET_POLARITY_EN
    ,
    output logic                 hsync_pol,
    output logic                 vsync_pol
`endif
);
    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    localparam logic [BitWidth-1:0]  HMax      = {BitWidth{1'b1}};
    localparam logic [BitHeight-1:0] VMax      = {BitHeight{1'b1}};
    localparam logic [3:0]           MatchNeed = 4'(LockFrames - 1);

    state_t               state_q, state_d;
    logic                 hs_q, vs_q, de_q, hs_p_q, hs_p_d, vs_p_q, vs_p_d, de_p_q;
    logic [BitWidth-1:0]  hcnt_q, hcnt_d, hde_q, hde_d, ref_htot_q, ref_htot_d, ref_hact_q, ref_hact_d;
    logic                 line_de_q, line_de_d, ref_valid_q, ref_valid_d;
    logic                 ref_hact_valid_q, ref_hact_valid_d, bad_q, bad_d;
    logic [BitHeight-1:0] vcnt_q, vcnt_d, vact_cnt_q, vact_cnt_d;
    logic [3:0]           match_q, match_d;
    logic [BitWidth-1:0]  st_htot_q, st_htot_d, st_hact_q, st_hact_d;
    logic [BitHeight-1:0] st_vtot_q, st_vtot_d, st_vact_q, st_vact_d;
    logic [BitWidth-1:0]  h_total_q, h_total_d, h_active_q, h_active_d, x_q, x_d, x_n;
    logic [BitHeight-1:0] v_total_q, v_total_d, v_active_q, v_active_d, y_q, y_d, y_n;
    logic                 locked_q, locked_d, lock_lost_q, lock_lost_d, de_o_q, de_o_d;

    logic                 hs_eff, vs_eff, line_ev, frame_ev, de_rise, de_fall;
    logic                 line_bad, frame_bad, set_match, pol_chg, sat, publish;
    logic [BitWidth-1:0]  line_htot, cand_htot, cand_hact;
    logic [BitHeight-1:0] cand_vtot, cand_vact;

`ifdef TIMING_DET_POLARITY_EN
    localparam int PW = BitWidth + BitHeight;
    logic          hpol_q, hpol_d, vpol_q, vpol_d;
    logic [PW-1:0] hhi_q, hhi_d, hlo_q, hlo_d;
    logic [BitHeight-1:0] vhi_q, vhi_d, vlo_q, vlo_d;

    assign hs_eff    = hs_q ^ hpol_q;
    assign vs_eff    = vs_q ^ vpol_q;
    assign hsync_pol = hpol_q;
    assign vsync_pol = vpol_q;

    // The level occupying the larger share of the frame is the inactive one.
    always_comb begin
        hpol_d = hpol_q;
        vpol_d = vpol_q;
        hhi_d  = hs_q ? hhi_q + 1'b1 : hhi_q;
        hlo_d  = hs_q ? hlo_q : hlo_q + 1'b1;
        vhi_d  = (line_ev && vs_q)  ? vhi_q + 1'b1 : vhi_q;
        vlo_d  = (line_ev && !vs_q) ? vlo_q + 1'b1 : vlo_q;
        if (frame_ev) begin
            hpol_d = hhi_q > hlo_q;
            vpol_d = vhi_q > vlo_q;
            hhi_d  = '0;
            hlo_d  = '0;
            vhi_d  = '0;
            vlo_d  = '0;
        end
        pol_chg = frame_ev && ((hpol_d != hpol_q) || (vpol_d != vpol_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hpol_q <= 1'b0;
            vpol_q <= 1'b0;
            hhi_q  <= '0;
            hlo_q  <= '0;
            vhi_q  <= '0;
            vlo_q  <= '0;
        end else begin
            hpol_q <= hpol_d;
            vpol_q <= vpol_d;
            hhi_q  <= hhi_d;
            hlo_q  <= hlo_d;
            vhi_q  <= vhi_d;
            vlo_q  <= vlo_d;
        end
    end
`else
    assign hs_eff  = hs_q;
    assign vs_eff  = vs_q;
    assign pol_chg = 1'b0;
`endif

    assign hs_p_d   = hs_eff;
    assign vs_p_d   = vs_eff;
    assign line_ev  = hs_eff & ~hs_p_q;
    assign frame_ev = vs_eff & ~vs_p_q;
    assign de_rise  = de_q & ~de_p_q;
    assign de_fall  = ~de_q & de_p_q;

    assign line_htot = hcnt_q + 1'b1;
    assign line_bad  = (line_htot != ref_htot_q) || (line_de_q && ref_hact_valid_q && (hde_q != ref_hact_q));
    // A line event coinciding with the frame event closes the last line of the ending frame.
    assign frame_bad = bad_q || (line_ev && ref_valid_q && line_bad);
    assign cand_htot = ref_valid_q ? ref_htot_q : line_htot;
    assign cand_hact = ref_hact_valid_q ? ref_hact_q : ((line_ev && line_de_q) ? hde_q : '0);
    assign cand_vtot = vcnt_q + BitHeight'(line_ev);
    assign cand_vact = vact_cnt_q + BitHeight'(line_ev && line_de_q);
    assign set_match = (cand_htot == st_htot_q) && (cand_hact == st_hact_q) &&
                       (cand_vtot == st_vtot_q) && (cand_vact == st_vact_q);
    assign sat       = ((hcnt_q == HMax) && !line_ev) || ((vcnt_q == VMax) && !frame_ev);

    always_comb begin
        state_d = state_q;  hcnt_d = hcnt_q;  hde_d = hde_q;  line_de_d = line_de_q;
        vcnt_d = vcnt_q;  vact_cnt_d = vact_cnt_q;  ref_valid_d = ref_valid_q;  ref_htot_d = ref_htot_q;
        ref_hact_valid_d = ref_hact_valid_q;  ref_hact_d = ref_hact_q;  bad_d = bad_q;  match_d = match_q;
        st_htot_d = st_htot_q;  st_hact_d = st_hact_q;  st_vtot_d = st_vtot_q;  st_vact_d = st_vact_q;
        h_total_d = h_total_q;  h_active_d = h_active_q;  v_total_d = v_total_q;  v_active_d = v_active_q;
        locked_d = locked_q;  lock_lost_d = 1'b0;  publish = 1'b0;

        if (line_ev) begin
            hcnt_d    = '0;
            hde_d     = BitWidth'(de_q);
            line_de_d = de_q;
            if (vcnt_q != VMax) vcnt_d = vcnt_q + 1'b1;
            if (line_de_q && (vact_cnt_q != VMax)) vact_cnt_d = vact_cnt_q + 1'b1;
            if (!ref_valid_q) begin
                ref_valid_d = 1'b1;
                ref_htot_d  = line_htot;
            end else if (line_bad) begin
                bad_d = 1'b1;
            end
            if (line_de_q && !ref_hact_valid_q) begin
                ref_hact_valid_d = 1'b1;
                ref_hact_d       = hde_q;
            end
        end else begin
            if (hcnt_q != HMax) hcnt_d = hcnt_q + 1'b1;
            if (de_q && (hde_q != HMax)) hde_d = hde_q + 1'b1;
            line_de_d = line_de_q | de_q;
        end
        if (frame_ev) begin
            vcnt_d = '0;  vact_cnt_d = '0;  ref_valid_d = 1'b0;  ref_hact_valid_d = 1'b0;  bad_d = 1'b0;
        end

        case (state_q)
            SEARCH:  if (frame_ev) state_d = MEASURE;
            MEASURE: if (frame_ev && !frame_bad) begin
                st_htot_d = cand_htot;  st_hact_d = cand_hact;  st_vtot_d = cand_vtot;  st_vact_d = cand_vact;
                match_d   = '0;
                if (MatchNeed == 4'd0) publish = 1'b1;
                else                   state_d = VERIFY;
            end
            VERIFY:  if (frame_ev) begin
                if (frame_bad || !set_match) begin
                    st_htot_d = cand_htot;  st_hact_d = cand_hact;  st_vtot_d = cand_vtot;  st_vact_d = cand_vact;
                    match_d   = '0;
                end else if ((match_q + 4'd1) >= MatchNeed) begin
                    publish = 1'b1;
                end else begin
                    match_d = match_q + 4'd1;
                end
            end
            LOCKED:  if (frame_ev && (frame_bad || !set_match || pol_chg)) begin
                state_d     = MEASURE;
                locked_d    = 1'b0;
                lock_lost_d = 1'b1;
            end
            default: state_d = SEARCH;
        endcase

        if (publish) begin
            state_d   = LOCKED;  locked_d   = 1'b1;
            h_total_d = cand_htot;  h_active_d = cand_hact;  v_total_d = cand_vtot;  v_active_d = cand_vact;
        end
        // A saturated counter means a sync has disappeared; drop straight back to searching.
        if (sat) begin
            state_d     = SEARCH;
            locked_d    = 1'b0;
            lock_lost_d = locked_q;
        end

        y_n = y_q;
        if (frame_ev)     y_n = '0;
        else if (de_fall) y_n = y_q + 1'b1;
        x_n = x_q;
        if (de_rise)      x_n = '0;
        else if (de_q)    x_n = x_q + 1'b1;
        x_d    = locked_d ? x_n : '0;
        y_d    = locked_d ? y_n : '0;
        de_o_d = locked_d & de_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;  hs_q <= 1'b0;  vs_q <= 1'b0;  de_q <= 1'b0;
            hs_p_q <= 1'b0;  vs_p_q <= 1'b0;  de_p_q <= 1'b0;
            hcnt_q <= '0;  hde_q <= '0;  line_de_q <= 1'b0;  vcnt_q <= '0;  vact_cnt_q <= '0;
            ref_valid_q <= 1'b0;  ref_htot_q <= '0;  ref_hact_valid_q <= 1'b0;  ref_hact_q <= '0;
            bad_q <= 1'b0;  match_q <= '0;
            st_htot_q <= '0;  st_hact_q <= '0;  st_vtot_q <= '0;  st_vact_q <= '0;
            h_total_q <= '0;  h_active_q <= '0;  v_total_q <= '0;  v_active_q <= '0;
            locked_q <= 1'b0;  lock_lost_q <= 1'b0;  x_q <= '0;  y_q <= '0;  de_o_q <= 1'b0;
        end else begin
            state_q <= state_d;  hs_q <= hsync;  vs_q <= vsync;  de_q <= de;
            hs_p_q <= hs_p_d;  vs_p_q <= vs_p_d;  de_p_q <= de_q;
            hcnt_q <= hcnt_d;  hde_q <= hde_d;  line_de_q <= line_de_d;  vcnt_q <= vcnt_d;  vact_cnt_q <= vact_cnt_d;
            ref_valid_q <= ref_valid_d;  ref_htot_q <= ref_htot_d;
            ref_hact_valid_q <= ref_hact_valid_d;  ref_hact_q <= ref_hact_d;
            bad_q <= bad_d;  match_q <= match_d;
            st_htot_q <= st_htot_d;  st_hact_q <= st_hact_d;  st_vtot_q <= st_vtot_d;  st_vact_q <= st_vact_d;
            h_total_q <= h_total_d;  h_active_q <= h_active_d;  v_total_q <= v_total_d;  v_active_q <= v_active_d;
            locked_q <= locked_d;  lock_lost_q <= lock_lost_d;  x_q <= x_d;  y_q <= y_d;  de_o_q <= de_o_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign de_o      = de_o_q;
    assign h_total   = h_total_q;
    assign h_active  = h_active_q;
    assign v_total   = v_total_q;
    assign v_active  = v_active_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
endmodule
